// File: rtl/cpu_pkg.sv
// Shared constants for the accumulator CPU: opcodes, FSM encoding, default widths.
package cpu_pkg;

    localparam int AW_DEF = 6;
    localparam int DW_DEF = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_INC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_DECODE = 2'b10,
        ST_EXEC   = 2'b11
    } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: ADD/INC produce a DW+1 bit sum, AND is bitwise, JMP passes ac.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [1:0]    op,
    input  logic [DW-1:0] ac,
    input  logic [DW-1:0] operand,
    output logic [DW-1:0] result,
    output logic          carry
);

    logic [DW:0] sum;

    // Select the operation; carry is only meaningful for ADD and INC
    always_comb begin
        sum    = '0;
        result = ac;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, ac} + {1'b0, operand};
                result = sum[DW-1:0];
                carry  = sum[DW];
            end
            OP_AND: result = ac & operand;
            OP_INC: begin
                sum    = {1'b0, ac} + {{DW{1'b0}}, 1'b1};
                result = sum[DW-1:0];
                carry  = sum[DW];
            end
            default: result = ac;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle accumulator CPU: IDLE/FETCH/DECODE/EXEC FSM, registers and memory address mux.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    output logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] ac,
    output logic [AW-1:0] pc,
    output logic          c_flag,
    output logic          z_flag,
    output logic          busy,
    output logic          instr_done
);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ac_q, ac_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] mdr_q, mdr_d;
    logic          c_q, c_d;
    logic          z_q, z_d;

    logic [1:0]    opcode;
    logic [AW-1:0] op_addr;
    logic [DW-1:0] alu_result;
    logic          alu_carry;

    assign opcode  = ir_q[DW-1:DW-2];
    assign op_addr = ir_q[AW-1:0];

    cpu_alu #(.DW(DW)) u_alu (
        .op      (opcode),
        .ac      (ac_q),
        .operand (mdr_q),
        .result  (alu_result),
        .carry   (alu_carry)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: run is only looked at in IDLE and on an instruction's last cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = run ? ST_FETCH : ST_IDLE;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (opcode == OP_INC || opcode == OP_JMP)
                    state_d = run ? ST_FETCH : ST_IDLE;
                else
                    state_d = ST_EXEC;
            end
            ST_EXEC:   state_d = run ? ST_FETCH : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: memory address, busy, end-of-instruction pulse
    always_comb begin
        addr       = pc_q;
        busy       = (state_q != ST_IDLE);
        instr_done = 1'b0;
        case (state_q)
            ST_DECODE: begin
                if (opcode == OP_INC || opcode == OP_JMP) instr_done = 1'b1;
                else                                      addr       = op_addr;
            end
            ST_EXEC:   instr_done = 1'b1;
            default:   ;
        endcase
    end

    // Datapath next values; z tracks every ac write
    always_comb begin
        pc_d  = pc_q;
        ac_d  = ac_q;
        ir_d  = ir_q;
        mdr_d = mdr_q;
        c_d   = c_q;
        z_d   = z_q;
        case (state_q)
            ST_FETCH: begin
                ir_d = data;
                pc_d = pc_q + 1'b1;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_INC: begin
                        ac_d = alu_result;
                        c_d  = alu_carry;
                        z_d  = (alu_result == '0);
                    end
                    OP_JMP:  pc_d  = op_addr;
                    default: mdr_d = data;
                endcase
            end
            ST_EXEC: begin
                ac_d = alu_result;
                z_d  = (alu_result == '0);
                if (opcode == OP_ADD) c_d = alu_carry;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            ac_q  <= '0;
            ir_q  <= '0;
            mdr_q <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b1;
        end else begin
            pc_q  <= pc_d;
            ac_q  <= ac_d;
            ir_q  <= ir_d;
            mdr_q <= mdr_d;
            c_q   <= c_d;
            z_q   <= z_d;
        end
    end

    assign ac     = ac_q;
    assign pc     = pc_q;
    assign c_flag = c_q;
    assign z_flag = z_q;

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: expected post-instruction state is queued by
// the stimulus, and a monitor pops and compares on each instr_done pulse.
module tb_cpu_core;

    typedef struct {
        logic [7:0] ac;
        logic [5:0] pc;
        logic       c;
        logic       z;
        int         cyc;
    } exp_t;

    logic       clk, rst_n, run;
    logic [5:0] addr, pc;
    logic [7:0] data, ac;
    logic       c_flag, z_flag, busy, instr_done;

    logic [7:0] mem [0:63];
    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    string      scen  = "init";

    assign data = mem[addr];

    cpu_core #(.AW(6), .DW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .addr       (addr),
        .data       (data),
        .ac         (ac),
        .pc         (pc),
        .c_flag     (c_flag),
        .z_flag     (z_flag),
        .busy       (busy),
        .instr_done (instr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %h expected %h", scen, name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [5:0] p, input logic c, input logic z, input int cyc);
        exp_t e;
        e.ac = a; e.pc = p; e.c = c; e.z = z; e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Monitor: count busy cycles per instruction, compare state after the done edge
    initial begin
        int   cyc;
        int   cs;
        exp_t e;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0;
            end else begin
                if (busy) cyc++;
                if (instr_done) begin
                    cs  = cyc;
                    cyc = 0;
                    @(posedge clk);
                    #1;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL %s unexpected_instr_done: got pc %0d ac %h, expected no instruction", scen, pc, ac);
                    end else begin
                        e = sb.pop_front();
                        chk("cycles", cs, e.cyc);
                        chk("ac", ac, e.ac);
                        chk("pc", pc, e.pc);
                        chk("c_flag", c_flag, e.c);
                        chk("z_flag", z_flag, e.z);
                    end
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    endtask

    task automatic base_mem();
        clear_mem();
        mem[0]  = 8'h3F;
        mem[1]  = 8'h7E;
        mem[2]  = 8'hC0;
        mem[3]  = 8'h82;
        mem[62] = 8'h20;
        mem[63] = 8'h3F;
    endtask

    task automatic do_reset();
        run   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst ac", ac, 8'h00);
        chk("rst pc", pc, 6'd0);
        chk("rst c", c_flag, 1'b0);
        chk("rst z", z_flag, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst done", instr_done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Wait for n instr_done pulses, then drop run in the last cycle of the nth
    task automatic run_instrs(input int n);
        int seen = 0;
        int t    = 0;
        while (seen < n && t < 200) begin
            @(negedge clk);
            t++;
            if (rst_n && instr_done) seen++;
        end
        if (seen < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: got %0d instr_done expected %0d", scen, seen, n);
        end
        run = 1'b0;
    endtask

    task automatic wait_first_busy();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!busy && t < 20);
        if (!busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s busy_timeout: got busy 0 expected 1", scen);
        end
    endtask

    task automatic settle_idle();
        repeat (4) @(negedge clk);
        chk("idle busy", busy, 1'b0);
        chk("sb drained", sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        base_mem();

        // Scenario 1: free run from reset through the INC/JMP loop
        scen = "s1";
        do_reset();
        push(8'h3F, 6'd1, 1'b0, 1'b0, 3);
        push(8'h20, 6'd2, 1'b0, 1'b0, 3);
        push(8'h21, 6'd3, 1'b0, 1'b0, 2);
        push(8'h21, 6'd2, 1'b0, 1'b0, 2);
        push(8'h22, 6'd3, 1'b0, 1'b0, 2);
        push(8'h22, 6'd2, 1'b0, 1'b0, 2);
        push(8'h23, 6'd3, 1'b0, 1'b0, 2);
        push(8'h23, 6'd2, 1'b0, 1'b0, 2);
        push(8'h24, 6'd3, 1'b0, 1'b0, 2);
        run = 1'b1;
        run_instrs(9);
        settle_idle();

        // Scenario 2: ac = 0xFF then INC wraps to zero with carry
        scen = "s2";
        clear_mem();
        mem[0] = 8'h05;
        mem[1] = 8'hC0;
        mem[5] = 8'hFF;
        do_reset();
        push(8'hFF, 6'd1, 1'b0, 1'b0, 3);
        push(8'h00, 6'd2, 1'b1, 1'b1, 2);
        run = 1'b1;
        run_instrs(2);
        settle_idle();

        // Scenario 3: drop run during DECODE of the first ADD
        scen = "s3";
        base_mem();
        do_reset();
        push(8'h3F, 6'd1, 1'b0, 1'b0, 3);
        run = 1'b1;
        wait_first_busy();
        @(negedge clk);
        run = 1'b0;
        repeat (4) @(negedge clk);
        chk("stop busy", busy, 1'b0);
        chk("stop pc", pc, 6'd1);
        chk("stop ac", ac, 8'h3F);
        chk("stop addr", addr, 6'd1);
        push(8'h20, 6'd2, 1'b0, 1'b0, 3);
        run = 1'b1;
        run_instrs(1);
        settle_idle();

        // Scenario 4: JMP 63 onto INC, pc wraps, refetch from 0
        scen = "s4";
        clear_mem();
        mem[0]  = 8'hBF;
        mem[63] = 8'hC0;
        do_reset();
        push(8'h00, 6'd63, 1'b0, 1'b1, 2);
        push(8'h01, 6'd0,  1'b0, 1'b0, 2);
        push(8'h01, 6'd63, 1'b0, 1'b0, 2);
        run = 1'b1;
        run_instrs(3);
        settle_idle();

        // Scenario 5: asynchronous reset in EXEC of the first ADD
        scen = "s5";
        base_mem();
        do_reset();
        run = 1'b1;
        wait_first_busy();
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("exec done", instr_done, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async ac", ac, 8'h00);
        chk("async pc", pc, 6'd0);
        chk("async z", z_flag, 1'b1);
        chk("async c", c_flag, 1'b0);
        chk("async busy", busy, 1'b0);
        chk("async done", instr_done, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk("post-rst ac", ac, 8'h00);
        chk("post-rst addr", addr, 6'd0);
        push(8'h3F, 6'd1, 1'b0, 1'b0, 3);
        push(8'h20, 6'd2, 1'b0, 1'b0, 3);
        run_instrs(2);
        settle_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected summary");
        $fatal(1, "watchdog");
    end

endmodule
